vram_write_arbiter: RTL

- Owns the single write port of the character VRAM (13-bit address, 8-bit ASCII data).
- Shares the port between NREQ requesters using round-robin arbitration. Example requesters: the pipeline-debug overlay writer and a CPU console port.
- Contains a clear-screen engine that fills the whole VRAM with a fill character.
- Runs in the VGA/VRAM clock domain (Div[1]) and sits between the requesters and the VRAM write port.

---
 rtl/vram_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/vram_write_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared constants and types for the character-VRAM write path.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int          VRAM_ADDR_W = 13;
    localparam int          VRAM_DATA_W = 8;
    localparam int          VRAM_CELLS  = 4800;   // 80 x 60 character cells
    localparam logic [7:0]  CHAR_SPACE  = 8'h20;

    // Write-port owner: normal arbitration or the clear-screen engine
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // Width of an index that can name one of n requesters
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant selection. Searches upward
//               from ptr (wrapping at N) for the first active request.
//               The pointer register is owned by the instantiating block.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import vram_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // First requester at or after ptr, modulo N, wins; nothing when disabled
    always_comb begin
        int   w_j;
        logic w_found;
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(ptr) + k) % N;
            if (en && !w_found && req[w_j]) begin
                gnt[w_j] = 1'b1;
                idx      = IW'(w_j);
                w_found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_write_arbiter
// Description : Owns the character-VRAM write port. Shares it between NREQ
//               requesters round-robin and contains a clear-screen engine
//               that fills DEPTH cells with FILL_CHAR.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_write_arbiter
    import vram_pkg::*;
#(
    parameter int                NREQ      = 2,
    parameter int                ADDR_W    = VRAM_ADDR_W,
    parameter int                DATA_W    = VRAM_DATA_W,
    parameter int                DEPTH     = VRAM_CELLS,
    parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(CHAR_SPACE)
) (
    input  logic                     clk,
    input  logic                     RSTN,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     vram_we,
    output logic [ADDR_W-1:0]        vram_write_addr,
    output logic [DATA_W-1:0]        vram_data_in
);

    localparam int PW = idx_w(NREQ);

    // The clear counter is ADDR_W wide, so every cleared cell must be addressable
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("vram_write_arbiter: DEPTH must be in 1..2**ADDR_W");
    end

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("vram_write_arbiter: NREQ must be in 2..4");
    end

    arb_state_t        r_state;
    logic [PW-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic              w_arb_en;
    logic [NREQ-1:0]   w_gnt;
    logic [PW-1:0]     w_idx;

    // A clear request pre-empts every requester in the cycle it arrives
    assign w_arb_en = RSTN && (r_state == ARB) && !clr_req;
    assign gnt      = w_gnt;

    rr_arbiter #(
        .N  (NREQ),
        .IW (PW)
    ) u_rr_arbiter (
        .req (req),
        .ptr (r_rr_ptr),
        .en  (w_arb_en),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    // Write-port sequencer: registers the winning write or the next fill cell
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_state         <= ARB;
            r_rr_ptr        <= '0;
            r_clr_cnt       <= '0;
            vram_we         <= 1'b0;
            vram_write_addr <= '0;
            vram_data_in    <= '0;
            clr_busy        <= 1'b0;
            clr_done        <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (r_state)
                ARB: begin
                    if (clr_req) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                        clr_busy  <= 1'b1;
                        vram_we   <= 1'b0;
                    end else if (|w_gnt) begin
                        vram_we         <= 1'b1;
                        vram_write_addr <= req_addr[w_idx*ADDR_W +: ADDR_W];
                        vram_data_in    <= req_data[w_idx*DATA_W +: DATA_W];
                        r_rr_ptr        <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;
                    end else begin
                        // Address and data keep their last values when idle
                        vram_we <= 1'b0;
                    end
                end
                CLEAR: begin
                    // Further clr_req pulses are ignored until the fill completes
                    vram_we         <= 1'b1;
                    vram_write_addr <= r_clr_cnt;
                    vram_data_in    <= FILL_CHAR;
                    if (r_clr_cnt == ADDR_W'(DEPTH-1)) begin
                        r_state  <= ARB;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

endmodule
`default_nettype wire
